// File: rtl/spi_pkg.sv
// Shared definitions for the memory-mapped SPI master: register map,
// chip-select mode encodings and shift-engine state encoding.
// Optional build macro: SPI_LOOPBACK_EN (see spi_mmio.sv).
package spi_pkg;

  localparam logic [31:0] ADDR_SCKDIV = 32'h1002_4000;
  localparam logic [31:0] ADDR_CSMODE = 32'h1002_4018;
  localparam logic [31:0] ADDR_TXDATA = 32'h1002_4048;
  localparam logic [31:0] ADDR_RXDATA = 32'h1002_404c;

  // Mode 1 is not listed; it falls through to AUTO behaviour.
  localparam logic [1:0] CS_AUTO = 2'd0;
  localparam logic [1:0] CS_HOLD = 2'd2;
  localparam logic [1:0] CS_OFF  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_e;

  function automatic logic is_spi_reg(input logic [31:0] addr);
    return (addr == ADDR_SCKDIV) || (addr == ADDR_CSMODE) ||
           (addr == ADDR_TXDATA) || (addr == ADDR_RXDATA);
  endfunction

endpackage

// File: rtl/spi_mmio_if.sv
// Memory request/response port between the processor and the SPI peripheral.
interface spi_mmio_if;
  logic        rq_en;
  logic [31:0] rq_addr;
  logic        rq_iswrite;
  logic [31:0] rq_wdata;
  logic        hit;
  logic        rs_en;
  logic [31:0] rs_data;

  modport master (output rq_en, rq_addr, rq_iswrite, rq_wdata,
                  input  hit, rs_en, rs_data);
  modport slave  (input  rq_en, rq_addr, rq_iswrite, rq_wdata,
                  output hit, rs_en, rs_data);
endinterface

// File: rtl/spi_shift_engine.sv
// Mode-0 MSB-first byte shifter: SCK divider, bit counter and shift register.
// The MISO sample taken on the rising phase is held aside and only shifted in
// at the end of the high phase, so the outgoing bits are never disturbed.
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_div,
  input  logic [7:0]       i_txbyte,
  input  logic             i_miso,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_rxbyte,
  output logic             o_sck,
  output logic             o_mosi
);

  spi_state_e       r_state;
  spi_state_e       w_state_next;
  logic [DIV_W-1:0] r_div_lat;
  logic [DIV_W-1:0] r_cnt;
  logic [3:0]       r_bits;
  logic [7:0]       r_shift;
  logic             r_miso_bit;
  logic             w_phase_end;

  assign w_phase_end = (r_cnt == r_div_lat);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: each SCK phase lasts div+1 clocks; eight high phases end the byte.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start)     w_state_next = ST_LOW;
      ST_LOW:  if (w_phase_end) w_state_next = ST_HIGH;
      ST_HIGH: if (w_phase_end) w_state_next = (r_bits == 4'd1) ? ST_IDLE : ST_LOW;
      default:                  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state and datapath registers.
  always_comb begin
    o_busy   = (r_state != ST_IDLE);
    o_sck    = (r_state == ST_HIGH);
    o_mosi   = (r_state != ST_IDLE) ? r_shift[7] : 1'b0;
    o_done   = (r_state == ST_HIGH) && w_phase_end && (r_bits == 4'd1);
    o_rxbyte = {r_shift[6:0], r_miso_bit};
  end

  // Divider, bit counter, shifter and MISO sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_lat  <= '0;
      r_cnt      <= '0;
      r_bits     <= 4'd0;
      r_shift    <= 8'h00;
      r_miso_bit <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (i_start) begin
        r_div_lat <= i_div;
        r_cnt     <= '0;
        r_bits    <= 4'd8;
        r_shift   <= i_txbyte;
      end
    end else if (w_phase_end) begin
      r_cnt <= '0;
      if (r_state == ST_LOW) begin
        r_miso_bit <= i_miso;
      end else begin
        r_shift <= {r_shift[6:0], r_miso_bit};
        r_bits  <= r_bits - 4'd1;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mmio.sv
// Memory-mapped SPI master: register decode, RX holding register, CS control
// and a one-cycle response pipeline in front of spi_shift_engine.
// Build macro SPI_LOOPBACK_EN: feed spi_mosi back as MISO, ignoring spi_miso.
module spi_mmio
  import spi_pkg::*;
#(
  parameter int DIV_W   = 12,
  parameter int DIV_RST = 3
) (
  input  logic        clk,
  input  logic        reset,
  spi_mmio_if.slave   bus,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  logic [DIV_W-1:0] r_sckdiv;
  logic [1:0]       r_csmode;
  logic             r_rx_valid;
  logic [7:0]       r_rxbyte;
  logic             r_rs_en;
  logic [31:0]      r_rs_data;

  logic        w_accept, w_wr, w_rd;
  logic        w_busy, w_done, w_start, w_pop, w_miso;
  logic [7:0]  w_rxbyte;
  logic [31:0] w_rdata;

  assign bus.hit = is_spi_reg(bus.rq_addr);
  assign w_accept = bus.rq_en && bus.hit;
  assign w_wr     = w_accept && bus.rq_iswrite;
  assign w_rd     = w_accept && !bus.rq_iswrite;
  // A TXDATA write while busy (including the completion cycle) is dropped.
  assign w_start  = w_wr && (bus.rq_addr == ADDR_TXDATA) && !w_busy;
  assign w_pop    = w_rd && (bus.rq_addr == ADDR_RXDATA) && r_rx_valid;

`ifdef SPI_LOOPBACK_EN
  assign w_miso = spi_mosi;
`else
  assign w_miso = spi_miso;
`endif

  spi_shift_engine #(.DIV_W(DIV_W)) u_engine (
    .clk      (clk),
    .rst      (reset),
    .i_start  (w_start),
    .i_div    (r_sckdiv),
    .i_txbyte (bus.rq_wdata[7:0]),
    .i_miso   (w_miso),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_rxbyte (w_rxbyte),
    .o_sck    (spi_sck),
    .o_mosi   (spi_mosi)
  );

  // Read data mux; reads see register state from before the accepting edge.
  always_comb begin
    w_rdata = 32'h0;
    case (bus.rq_addr)
      ADDR_SCKDIV: w_rdata = 32'(r_sckdiv);
      ADDR_CSMODE: w_rdata = {30'h0, r_csmode};
      ADDR_TXDATA: w_rdata = {w_busy, 31'h0};
      ADDR_RXDATA: w_rdata = {~r_rx_valid, 23'h0, r_rxbyte};
      default:     w_rdata = 32'h0;
    endcase
  end

  // Chip select follows the mode register; AUTO tracks the engine's busy flag.
  always_comb begin
    case (r_csmode)
      CS_HOLD: spi_cs_n = 1'b0;
      CS_OFF:  spi_cs_n = 1'b1;
      default: spi_cs_n = ~w_busy;
    endcase
  end

  // Config registers and RX holding register; a completing byte wins over a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sckdiv   <= DIV_W'(DIV_RST);
      r_csmode   <= CS_AUTO;
      r_rx_valid <= 1'b0;
      r_rxbyte   <= 8'h00;
    end else begin
      if (w_wr && bus.rq_addr == ADDR_SCKDIV) r_sckdiv <= bus.rq_wdata[DIV_W-1:0];
      if (w_wr && bus.rq_addr == ADDR_CSMODE) r_csmode <= bus.rq_wdata[1:0];
      if (w_done) begin
        r_rxbyte   <= w_rxbyte;
        r_rx_valid <= 1'b1;
      end else if (w_pop) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  // Response pipeline: one strobe per accepted request, zero data for writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs_en   <= 1'b0;
      r_rs_data <= 32'h0;
    end else begin
      r_rs_en   <= w_accept;
      r_rs_data <= w_rd ? w_rdata : 32'h0;
    end
  end

  assign bus.rs_en   = r_rs_en;
  assign bus.rs_data = r_rs_data;

endmodule

// File: tb/tb_spi_mmio.sv
// Directed self-checking bench for spi_mmio.
module tb_spi_mmio;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic spi_sck, spi_mosi, spi_miso, spi_cs_n;
  logic loop = 1'b0;
  logic tb_miso = 1'b0;
  int   total = 0;
  int   bad = 0;

  spi_mmio_if bus ();

  assign spi_miso = loop ? spi_mosi : tb_miso;

  spi_mmio #(.DIV_W(12), .DIV_RST(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      output logic [31:0] rd);
    bus.rq_en = 1'b1; bus.rq_addr = a; bus.rq_iswrite = wr; bus.rq_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.rq_en = 1'b0; bus.rq_iswrite = 1'b0;
    rd = bus.rs_data;
    $display("txn %s addr=%h wdata=%h rs_en=%b rs_data=%h", wr ? "WR" : "RD", a, wd, bus.rs_en, rd);
    chk("rs_en", {31'h0, bus.rs_en}, 32'h1);
    if (wr) chk("wr_rs_data", rd, 32'h0);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  tx_pat, rx_pat, rx_exp;
    int sck_err, cs_err;

    bus.rq_en = 1'b0; bus.rq_addr = 32'h0; bus.rq_iswrite = 1'b0; bus.rq_wdata = 32'h0;

    // Reset state
    wait_n(2);
    chk("rst_rs_en", {31'h0, bus.rs_en}, 32'h0);
    chk("rst_rs_data", bus.rs_data, 32'h0);
    chk("rst_sck", {31'h0, spi_sck}, 32'h0);
    chk("rst_mosi", {31'h0, spi_mosi}, 32'h0);
    chk("rst_cs_n", {31'h0, spi_cs_n}, 32'h1);
    reset = 1'b0;
    wait_n(1);

    xfer(ADDR_SCKDIV, 1'b0, 0, rd); chk("sckdiv_rst", rd, 32'h3);
    xfer(ADDR_CSMODE, 1'b0, 0, rd); chk("csmode_rst", rd, 32'h0);
    xfer(ADDR_TXDATA, 1'b0, 0, rd); chk("tx_idle", rd, 32'h0);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_empty", rd, 32'h8000_0000);

    // Non-hit request
    bus.rq_en = 1'b1; bus.rq_addr = 32'h1002_4004; bus.rq_iswrite = 1'b0;
    #1 chk("nohit_hit", {31'h0, bus.hit}, 32'h0);
    @(posedge clk); @(negedge clk);
    bus.rq_en = 1'b0;
    chk("nohit_rs_en", {31'h0, bus.rs_en}, 32'h0);
    bus.rq_addr = ADDR_RXDATA;
    #1 chk("hit_rx", {31'h0, bus.hit}, 32'h1);
    @(negedge clk);

    // SCKDIV=3, TX 0x3C with external MISO 0x96
    tx_pat = 8'h3C; rx_pat = 8'h96; sck_err = 0; cs_err = 0;
    xfer(ADDR_SCKDIV, 1'b1, 32'h3, rd);
    xfer(ADDR_TXDATA, 1'b1, {24'h0, tx_pat}, rd);
    for (int k = 0; k < 64; k++) begin
      if (spi_sck !== (((k / 4) % 2) == 1)) sck_err++;
      if (spi_cs_n !== 1'b0) cs_err++;
      if (k % 8 == 2) chk("mosi_3c", {31'h0, spi_mosi}, {31'h0, tx_pat[7 - k / 8]});
      tb_miso = rx_pat[7 - k / 8];
      @(negedge clk);
    end
    chk("sck_phases_div3", sck_err, 0);
    chk("cs_low_busy", cs_err, 0);
    chk("end_sck", {31'h0, spi_sck}, 32'h0);
    chk("end_cs_n", {31'h0, spi_cs_n}, 32'h1);
`ifdef SPI_LOOPBACK_EN
    rx_exp = tx_pat;
`else
    rx_exp = rx_pat;
`endif
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_ext", rd, {24'h0, rx_exp});
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_popped", rd, {24'h8000_00, rx_exp});

    // Loopback, SCKDIV=0, TX 0xA5: 16-cycle transfer
    loop = 1'b1;
    xfer(ADDR_SCKDIV, 1'b1, 32'h0, rd);
    xfer(ADDR_TXDATA, 1'b1, 32'hA5, rd);
    xfer(ADDR_TXDATA, 1'b0, 0, rd); chk("tx_busy", rd, 32'h8000_0000);
    wait_n(14);
    chk("k15_cs_n", {31'h0, spi_cs_n}, 32'h0);
    chk("k15_sck", {31'h0, spi_sck}, 32'h1);
    wait_n(1);
    chk("k16_cs_n", {31'h0, spi_cs_n}, 32'h1);
    chk("k16_sck", {31'h0, spi_sck}, 32'h0);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_a5", rd, 32'h0000_00A5);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_a5_empty", rd, 32'h8000_00A5);

    // Write while busy is dropped
    xfer(ADDR_TXDATA, 1'b1, 32'h11, rd);
    xfer(ADDR_TXDATA, 1'b1, 32'h22, rd);
    wait_n(16);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_drop", rd, 32'h0000_0011);

    // TXDATA write in completion cycle is dropped
    xfer(ADDR_TXDATA, 1'b1, 32'h77, rd);
    wait_n(15);
    xfer(ADDR_TXDATA, 1'b1, 32'hEE, rd);
    xfer(ADDR_TXDATA, 1'b0, 0, rd); chk("tx_done_drop", rd, 32'h0);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_77", rd, 32'h0000_0077);

    // RXDATA read in completion cycle with valid=0
    xfer(ADDR_TXDATA, 1'b1, 32'h5A, rd);
    wait_n(15);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_coinc", rd, 32'h8000_0077);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_5a", rd, 32'h0000_005A);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_5a_empty", rd, 32'h8000_005A);

    // CSMODE HOLD across two transfers, with overwrite of unread byte
    xfer(ADDR_CSMODE, 1'b1, 32'h2, rd);
    chk("hold_idle_cs", {31'h0, spi_cs_n}, 32'h0);
    cs_err = 0;
    xfer(ADDR_TXDATA, 1'b1, 32'h01, rd);
    for (int k = 0; k < 17; k++) begin
      if (spi_cs_n !== 1'b0) cs_err++;
      @(negedge clk);
    end
    xfer(ADDR_TXDATA, 1'b1, 32'h02, rd);
    for (int k = 0; k < 17; k++) begin
      if (spi_cs_n !== 1'b0) cs_err++;
      @(negedge clk);
    end
    chk("hold_cs_low", cs_err, 0);
    xfer(ADDR_CSMODE, 1'b0, 0, rd); chk("csmode_2", rd, 32'h2);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_overwrite", rd, 32'h0000_0002);

    // CSMODE OFF
    xfer(ADDR_CSMODE, 1'b1, 32'h3, rd);
    cs_err = 0;
    xfer(ADDR_TXDATA, 1'b1, 32'h03, rd);
    for (int k = 0; k < 17; k++) begin
      if (spi_cs_n !== 1'b1) cs_err++;
      @(negedge clk);
    end
    chk("off_cs_high", cs_err, 0);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rx_03", rd, 32'h0000_0003);
    xfer(ADDR_CSMODE, 1'b1, 32'h0, rd);

    // Reset mid-transfer, SCKDIV=5
    xfer(ADDR_SCKDIV, 1'b1, 32'h5, rd);
    xfer(ADDR_TXDATA, 1'b1, 32'hFF, rd);
    wait_n(56);
    chk("pre_rst_sck", {31'h0, spi_sck}, 32'h1);
    chk("pre_rst_cs", {31'h0, spi_cs_n}, 32'h0);
    chk("pre_rst_mosi", {31'h0, spi_mosi}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_sck", {31'h0, spi_sck}, 32'h0);
    chk("rst_mid_cs", {31'h0, spi_cs_n}, 32'h1);
    chk("rst_mid_mosi", {31'h0, spi_mosi}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_n(1);
    xfer(ADDR_TXDATA, 1'b0, 0, rd); chk("rst_tx", rd, 32'h0);
    xfer(ADDR_SCKDIV, 1'b0, 0, rd); chk("rst_sckdiv", rd, 32'h3);
    xfer(ADDR_RXDATA, 1'b0, 0, rd); chk("rst_rx", rd, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
